pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder_pkg.sv | 12 +
 rtl/addsub_chunk.sv | 18 +
 rtl/pipe_adder.sv | 133 +++++++++++++
 tb/tb_pipe_adder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_adder_pkg.sv
// Shared types and default sizing for the pipelined adder/subtractor.
package pipe_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int unsigned DEFAULT_WIDTH  = 16;
    localparam int unsigned DEFAULT_STAGES = 4;

endpackage

// File: rtl/addsub_chunk.sv
// One chunk of the carry chain: a plain WIDTH-bit ripple add with carry in/out.
module addsub_chunk #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    logic [WIDTH:0] sum;

    assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign s    = sum[WIDTH-1:0];
    assign cout = sum[WIDTH];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract, one CW-bit chunk per stage, valid/ready handshake.
// Optional PIPE_ADDER_SAT_EN clamps s to the signed range on overflow.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = WIDTH / STAGES;

    if (WIDTH % STAGES != 0) begin : g_width_check
        $error("pipe_adder: WIDTH must be a multiple of STAGES");
    end

    op_e              op;
    logic             advance;

    // Per-stage registers; a/bx travel full width so upper chunks reach their stage.
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  bx_q [STAGES];
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;

    // Inputs presented to each stage this cycle.
    logic [WIDTH-1:0]  st_a  [STAGES];
    logic [WIDTH-1:0]  st_bx [STAGES];
    logic [WIDTH-1:0]  st_s  [STAGES];
    logic [WIDTH-1:0]  nxt_s [STAGES];
    logic [STAGES-1:0] st_v;
    logic [STAGES-1:0] st_cin;

    logic [WIDTH-1:0]  ch_a;
    logic [WIDTH-1:0]  ch_b;
    logic [WIDTH-1:0]  ch_s;
    logic [STAGES-1:0] ch_c;
    logic [WIDTH-1:0]  raw_s;

    assign op       = sub ? OP_SUB : OP_ADD;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !rst;

    always_comb begin
        st_a[0]   = a;
        st_bx[0]  = b ^ {WIDTH{op == OP_SUB}};
        st_s[0]   = '0;
        st_cin[0] = (op == OP_SUB);
        st_v[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            st_a[k]   = a_q[k-1];
            st_bx[k]  = bx_q[k-1];
            st_s[k]   = s_q[k-1];
            st_cin[k] = c_q[k-1];
            st_v[k]   = v_q[k-1];
        end
        ch_a = '0;
        ch_b = '0;
        for (int k = 0; k < STAGES; k++) begin
            ch_a[k*CW +: CW] = st_a[k][k*CW +: CW];
            ch_b[k*CW +: CW] = st_bx[k][k*CW +: CW];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_s[k]              = st_s[k];
            nxt_s[k][k*CW +: CW]  = ch_s[k*CW +: CW];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        addsub_chunk #(
            .WIDTH (CW)
        ) u_chunk (
            .a    (ch_a[k*CW +: CW]),
            .b    (ch_b[k*CW +: CW]),
            .cin  (st_cin[k]),
            .s    (ch_s[k*CW +: CW]),
            .cout (ch_c[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= '0;
                bx_q[k] <= '0;
                s_q[k]  <= '0;
            end
        end else if (advance) begin
            v_q <= st_v;
            c_q <= ch_c;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]  <= st_a[k];
                bx_q[k] <= st_bx[k];
                s_q[k]  <= nxt_s[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign raw_s     = s_q[STAGES-1];
    // Carry into the MSB is recovered from the MSB sum bit: a ^ bx ^ s.
    assign ovf       = a_q[STAGES-1][WIDTH-1] ^ bx_q[STAGES-1][WIDTH-1]
                     ^ raw_s[WIDTH-1] ^ c_q[STAGES-1];

`ifdef PIPE_ADDER_SAT_EN
    // On overflow both effective operands share the sign of a.
    assign s = !ovf ? raw_s
             : (a_q[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign s = raw_s;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (WIDTH=16, STAGES=4).
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, s;

    logic [17:0] sb[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    logic [17:0] prev_out;
    logic        prev_hold = 1'b0;

    always #5 clk = ~clk;

    pipe_adder #(
        .WIDTH  (16),
        .STAGES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

`ifdef PIPE_ADDER_SAT_EN
    localparam logic [15:0] PosOvfS = 16'h7FFF;
    localparam logic [15:0] NegOvfS = 16'h8000;
`else
    localparam logic [15:0] PosOvfS = 16'h8000;
    localparam logic [15:0] NegOvfS = 16'h7FFF;
`endif

    // Reference: {s, cout, ovf}
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic op);
        logic [15:0] r;
        logic        c, v;
        r = op ? x - y : x + y;
        c = op ? (x >= y) : (({1'b0, x} + {1'b0, y}) > 17'h0FFFF);
        v = op ? (x[15] != y[15] && r[15] != x[15]) : (x[15] == y[15] && r[15] != x[15]);
`ifdef PIPE_ADDER_SAT_EN
        if (v) r = x[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {r, c, v};
    endfunction

    // Output side: pop and compare on each accepted result, check hold during stalls.
    always @(negedge clk) begin
        logic [17:0] exp;
        if (!rst && prev_hold) begin
            n_vec++;
            if (out_valid !== 1'b1 || {s, cout, ovf} !== prev_out) begin
                n_miss++;
                $display("FAIL stall_hold: got v=%b {s,c,o}=%h required v=1 %h",
                         out_valid, {s, cout, ovf}, prev_out);
            end
        end
        if (!rst && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_result: got {s,c,o}=%h, none pending",
                         {s, cout, ovf});
            end else begin
                exp = sb.pop_front();
                if ({s, cout, ovf} !== exp) begin
                    n_miss++;
                    $display("FAIL result: got s=%h c=%b o=%b required s=%h c=%b o=%b",
                             s, cout, ovf, exp[17:2], exp[1], exp[0]);
                end
            end
        end
        prev_hold = !rst && out_valid && !out_ready;
        prev_out  = {s, cout, ovf};
    end

    task automatic drive_cycle(input logic v, input logic [15:0] x, input logic [15:0] y,
                               input logic op, input logic [17:0] exp, output logic took);
        in_valid = v;
        a        = x;
        b        = y;
        sub      = op;
        @(negedge clk);
        took = v && in_ready;
        if (took) sb.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b0) begin
            n_miss++; $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        n_vec++;
        if ({out_valid, s, cout, ovf} !== 19'd0) begin
            n_miss++;
            $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b required all 0",
                     out_valid, s, cout, ovf);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++; $display("FAIL ready_after_reset: got %b required 1", in_ready);
        end
    endtask

    task automatic test_latency;
        logic took;
        int   lat;
        out_ready = 1'b1;
        drive_cycle(1'b1, 16'd15, 16'd15, 1'b0, {16'd30, 1'b0, 1'b0}, took);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        n_vec++;
        if (!took || lat != 4) begin
            n_miss++; $display("FAIL latency: got took=%b cycles=%0d required 1, 4", took, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_edges;
        logic took;
        out_ready = 1'b1;
        drive_cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0}, took);
        drive_cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, {PosOvfS, 1'b0, 1'b1}, took);
        drive_cycle(1'b1, 16'd5, 16'd7, 1'b1, {16'hFFFE, 1'b0, 1'b0}, took);
        drive_cycle(1'b1, 16'h8000, 16'h0001, 1'b1, {NegOvfS, 1'b1, 1'b1}, took);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++; $display("FAIL edges_drain: got %0d pending required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] xs[8];
        logic [15:0] ys[8];
        logic        ops[8];
        logic        took;
        int          idx = 0;
        for (int i = 0; i < 8; i++) begin
            xs[i] = 16'(1000 * i + 3); ys[i] = 16'(77 * i + 1); ops[i] = i[0];
        end
        for (int cyc = 0; cyc < 60 && (idx < 8 || sb.size() != 0); cyc++) begin
            out_ready = !(cyc >= 5 && cyc < 8);
            #1;
            if (!out_ready) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_miss++;
                    $display("FAIL stall_in_ready: cycle %0d got %b required 0", cyc, in_ready);
                end
            end
            if (idx < 8) begin
                drive_cycle(1'b1, xs[idx], ys[idx], ops[idx],
                            model(xs[idx], ys[idx], ops[idx]), took);
                if (took) idx++;
            end else begin
                drive_cycle(1'b0, 16'h0, 16'h0, 1'b0, 18'h0, took);
            end
        end
        n_vec++;
        if (idx != 8 || sb.size() != 0) begin
            n_miss++;
            $display("FAIL b2b_complete: got issued=%0d pending=%0d required 8, 0",
                     idx, sb.size());
        end
    endtask

    task automatic test_reset_mid;
        logic took;
        int   stale = 0;
        out_ready = 1'b1;
        drive_cycle(1'b1, 16'h1234, 16'h1111, 1'b0, model(16'h1234, 16'h1111, 1'b0), took);
        drive_cycle(1'b1, 16'h4000, 16'h4000, 1'b0, model(16'h4000, 16'h4000, 1'b0), took);
        drive_cycle(1'b1, 16'h0003, 16'h0009, 1'b1, model(16'h0003, 16'h0009, 1'b1), took);
        in_valid = 1'b0;
        rst      = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if ({out_valid, s, cout, ovf} !== 19'd0) begin
            n_miss++;
            $display("FAIL reset_mid_outputs: got v=%b s=%h c=%b o=%b required all 0",
                     out_valid, s, cout, ovf);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        @(posedge clk); #1;
        n_vec++;
        if (stale != 0) begin
            n_miss++; $display("FAIL reset_mid_stale: got %0d results required 0", stale);
        end
    endtask

    task automatic test_random;
        logic        took, v, op;
        logic [15:0] x, y;
        for (int i = 0; i < 60; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            v  = ($urandom_range(0, 3) != 0);
            x  = 16'($urandom);
            y  = 16'($urandom);
            op = 1'($urandom_range(0, 1));
            drive_cycle(v, x, y, op, model(x, y, op), took);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++; $display("FAIL random_drain: got %0d pending required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_edges();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
